// File: rtl/bcd_digit_packer_if.sv
// Digit-entry and packed-result handshake bundle for bcd_digit_packer.
// slave is the packer itself; master is the keypad/serial source plus the downstream converter.
interface bcd_digit_packer_if;
   logic [3:0] digit_in;
   logic       digit_valid;
   logic       digit_ready;
   logic       enter;
   logic       clear;
   logic [7:0] bcd_out;
   logic       out_valid;
   logic       out_ready;
   logic       err_valid;
   logic [1:0] err_code;

   modport slave (
      input  digit_in, digit_valid, enter, clear, out_ready,
      output digit_ready, bcd_out, out_valid, err_valid, err_code
   );

   modport master (
      output digit_in, digit_valid, enter, clear, out_ready,
      input  digit_ready, bcd_out, out_valid, err_valid, err_code
   );
endinterface

// File: rtl/bcd_digit_packer.sv
// Assembles BCD digits calculator-style into a packed two-digit byte and
// presents it, range-checked against MAX_VAL, over a valid/ready output.
module bcd_digit_packer #(
   parameter int unsigned MAX_VAL = 15
) (
   input  logic               clk,
   input  logic               rst,
   bcd_digit_packer_if.slave  bus
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO, HOLD} state_t;

   localparam logic [6:0] MAX_V = 7'(MAX_VAL);
   localparam logic [1:0] ERR_DIGIT = 2'b01;
   localparam logic [1:0] ERR_OVF   = 2'b10;
   localparam logic [1:0] ERR_EMPTY = 2'b11;

   state_t     state_reg, state_next;
   logic [3:0] tens_reg, tens_next;
   logic [3:0] ones_reg, ones_next;
   logic [7:0] bcd_reg, bcd_next;
   logic       out_valid_reg, out_valid_next;
   logic       err_valid_reg, err_valid_next;
   logic [1:0] err_code_reg, err_code_next;

   logic       dig_xfer, dig_ok, dig_bad;
   state_t     cand_state;
   logic [3:0] cand_tens, cand_ones;
   logic       cand_empty;
   logic [6:0] cand_value;

   assign bus.digit_ready = (state_reg != HOLD);
   assign bus.bcd_out     = bcd_reg;
   assign bus.out_valid   = out_valid_reg;
   assign bus.err_valid   = err_valid_reg;
   assign bus.err_code    = err_code_reg;

   assign dig_xfer = bus.digit_valid & bus.digit_ready;
   assign dig_ok   = dig_xfer & (bus.digit_in <= 4'd9);
   assign dig_bad  = dig_xfer & (bus.digit_in > 4'd9);

   // Candidate value includes a digit accepted in the same cycle as enter.
   always_comb begin
      cand_state = state_reg;
      cand_tens  = tens_reg;
      cand_ones  = ones_reg;
      if (dig_ok) begin
         cand_tens = (state_reg == EMPTY) ? 4'd0 : ones_reg;
         cand_ones = bus.digit_in;
         cand_state = (state_reg == EMPTY) ? ONE : TWO;
      end
      cand_empty = (state_reg == EMPTY) && !dig_ok;
      cand_value = 7'(cand_tens) * 7'd10 + 7'(cand_ones);
   end

   always_comb begin
      state_next     = state_reg;
      tens_next      = tens_reg;
      ones_next      = ones_reg;
      bcd_next       = bcd_reg;
      out_valid_next = out_valid_reg;
      err_valid_next = 1'b0;
      err_code_next  = err_code_reg;

      if (bus.clear) begin
         state_next     = EMPTY;
         tens_next      = 4'd0;
         ones_next      = 4'd0;
         out_valid_next = 1'b0;
      end else if (state_reg == HOLD) begin
         if (bus.out_ready) begin
            state_next     = EMPTY;
            tens_next      = 4'd0;
            ones_next      = 4'd0;
            out_valid_next = 1'b0;
         end
      end else begin
         state_next = cand_state;
         tens_next  = cand_tens;
         ones_next  = cand_ones;
         if (dig_bad) begin
            err_valid_next = 1'b1;
            err_code_next  = ERR_DIGIT;
         end
         // A failing commit overrides the invalid-digit code in the same cycle.
         if (bus.enter) begin
            if (cand_empty) begin
               err_valid_next = 1'b1;
               err_code_next  = ERR_EMPTY;
            end else if (cand_value > MAX_V) begin
               err_valid_next = 1'b1;
               err_code_next  = ERR_OVF;
               tens_next      = 4'd0;
               ones_next      = 4'd0;
               state_next     = EMPTY;
            end else begin
               bcd_next       = {cand_tens, cand_ones};
               out_valid_next = 1'b1;
               state_next     = HOLD;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= EMPTY;
         tens_reg      <= 4'd0;
         ones_reg      <= 4'd0;
         bcd_reg       <= 8'h00;
         out_valid_reg <= 1'b0;
         err_valid_reg <= 1'b0;
         err_code_reg  <= 2'b00;
      end else begin
         state_reg     <= state_next;
         tens_reg      <= tens_next;
         ones_reg      <= ones_next;
         bcd_reg       <= bcd_next;
         out_valid_reg <= out_valid_next;
         err_valid_reg <= err_valid_next;
         err_code_reg  <= err_code_next;
      end
   end
endmodule

// File: tb/tb_bcd_digit_packer.sv
// Directed and randomized bench for bcd_digit_packer against a digit-list
// reference model that works on decimal values.
module tb_bcd_digit_packer;
   localparam int MAX_VAL = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   bcd_digit_packer_if bus();

   bcd_digit_packer #(.MAX_VAL(MAX_VAL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: the entered digits as a list, newest last.
   int         digs[$];
   bit         m_hold;
   logic [7:0] m_bcd;
   bit         m_ov;
   bit         m_ev;
   logic [1:0] m_ec;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int cur_value();
      if (digs.size() == 0) return 0;
      if (digs.size() == 1) return digs[0];
      return digs[digs.size()-2] * 10 + digs[digs.size()-1];
   endfunction

   task automatic model_reset();
      digs.delete();
      m_hold = 0;
      m_bcd  = 8'h00;
      m_ov   = 0;
      m_ev   = 0;
      m_ec   = 2'b00;
   endtask

   task automatic model_edge();
      int v;
      m_ev = 0;
      if (bus.clear) begin
         digs.delete();
         m_hold = 0;
         m_ov   = 0;
      end else if (m_hold) begin
         if (bus.out_ready) begin
            m_hold = 0;
            m_ov   = 0;
            digs.delete();
         end
      end else begin
         if (bus.digit_valid) begin
            if (int'(bus.digit_in) <= 9) digs.push_back(int'(bus.digit_in));
            else begin m_ev = 1; m_ec = 2'b01; end
         end
         if (bus.enter) begin
            if (digs.size() == 0) begin
               m_ev = 1; m_ec = 2'b11;
            end else begin
               v = cur_value();
               if (v > MAX_VAL) begin
                  m_ev = 1; m_ec = 2'b10;
                  digs.delete();
               end else begin
                  m_bcd  = 8'((v / 10) * 16 + (v % 10));
                  m_ov   = 1;
                  m_hold = 1;
               end
            end
         end
      end
      while (digs.size() > 2) void'(digs.pop_front());
   endtask

   task automatic check_all();
      chk("digit_ready", int'(bus.digit_ready), int'(!m_hold));
      chk("out_valid",   int'(bus.out_valid),   int'(m_ov));
      if (m_ov) chk("bcd_out", int'(bus.bcd_out), int'(m_bcd));
      chk("err_valid",   int'(bus.err_valid),   int'(m_ev));
      chk("err_code",    int'(bus.err_code),    int'(m_ec));
   endtask

   task automatic step(input logic dv, input logic [3:0] d, input logic en,
                       input logic cl, input logic ordy);
      bus.digit_valid = dv;
      bus.digit_in    = d;
      bus.enter       = en;
      bus.clear       = cl;
      bus.out_ready   = ordy;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.digit_valid = 1'b0;
      bus.digit_in    = 4'd0;
      bus.enter       = 1'b0;
      bus.clear       = 1'b0;
      bus.out_ready   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid",   int'(bus.out_valid),   0);
      chk("rst_bcd_out",     int'(bus.bcd_out),     0);
      chk("rst_err_valid",   int'(bus.err_valid),   0);
      chk("rst_err_code",    int'(bus.err_code),    0);
      chk("rst_digit_ready", int'(bus.digit_ready), 1);
      rst = 1'b0;

      // 1,2,enter -> 0x12, held while out_ready low, then transferred
      step(1, 4'd1, 0, 0, 0);
      step(1, 4'd2, 0, 0, 0);
      step(0, 4'd0, 1, 0, 0);
      chk("dir_12", int'(bus.bcd_out), 8'h12);
      idle(3);
      step(0, 4'd0, 0, 0, 1);
      // oldest digit dropped
      step(1, 4'd3, 0, 0, 0);
      step(1, 4'd1, 0, 0, 0);
      step(1, 4'd4, 0, 0, 0);
      step(0, 4'd0, 1, 0, 0);
      chk("dir_14", int'(bus.bcd_out), 8'h14);
      step(0, 4'd0, 0, 0, 1);
      // overflow, then empty commit
      step(1, 4'd1, 0, 0, 0);
      step(1, 4'd6, 0, 0, 0);
      step(0, 4'd0, 1, 0, 0);
      chk("dir_ovf", int'(bus.err_code), 2);
      step(0, 4'd0, 1, 0, 0);
      chk("dir_empty", int'(bus.err_code), 3);
      // invalid digit between 1 and 5
      step(1, 4'd1, 0, 0, 0);
      step(1, 4'hB, 0, 0, 0);
      chk("dir_inv", int'(bus.err_code), 1);
      step(1, 4'd5, 0, 0, 0);
      step(0, 4'd0, 1, 0, 0);
      chk("dir_15", int'(bus.bcd_out), 8'h15);
      step(0, 4'd0, 0, 0, 1);
      // same-cycle digit and enter; digit offered in HOLD is refused
      step(1, 4'd7, 1, 0, 0);
      chk("dir_07", int'(bus.bcd_out), 8'h07);
      step(1, 4'd9, 0, 0, 0);
      step(0, 4'd0, 0, 0, 1);
      // clear with digit, then clear with out_ready in HOLD
      step(1, 4'd1, 0, 0, 0);
      step(1, 4'd2, 0, 1, 0);
      step(1, 4'd3, 1, 0, 0);
      step(0, 4'd0, 0, 1, 1);
      // invalid digit with enter on an overflowing value: commit code wins
      step(1, 4'd9, 0, 0, 0);
      step(1, 4'd9, 0, 0, 0);
      step(1, 4'hC, 1, 0, 0);
      step(1, 4'hF, 1, 0, 0);
      // async reset mid-HOLD
      step(1, 4'd8, 1, 0, 0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("arst_out_valid", int'(bus.out_valid), 0);
      chk("arst_bcd_out",   int'(bus.bcd_out),   0);
      @(posedge clk);
      #1 rst = 1'b0;
      step(1, 4'd5, 0, 0, 0);
      step(0, 4'd0, 1, 0, 0);
      chk("arst_05", int'(bus.bcd_out), 8'h05);
      step(0, 4'd0, 0, 0, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic       dv, en, cl, ordy;
         logic [3:0] d;
         dv   = ($urandom_range(0, 9) < 6);
         d    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
         en   = ($urandom_range(0, 4) == 0);
         cl   = ($urandom_range(0, 29) == 0);
         ordy = ($urandom_range(0, 1) == 1);
         step(dv, d, en, cl, ordy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
